// File: rtl/rtc_settable_clk.sv
// Settable 24 h real-time clock with two-button set FSM, blinking edit field,
// 12/24 h display option and a 4-digit active-low seven-segment scan driver.
module rtc_settable_clk #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode,
  input  logic       fmt12,
  input  logic       btn_set,
  input  logic       btn_inc,
  output logic [3:0] basys_anode,
  output logic [6:0] display_ssd,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       pm,
  output logic [1:0] set_state,
  output logic       sec_tick
);

  localparam int unsigned DWELL      = CLK_HZ / (4 * REFRESH_HZ);
  localparam int unsigned BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned PW = (CLK_HZ > 1)     ? $clog2(CLK_HZ)     : 1;
  localparam int unsigned DW = (DWELL > 1)      ? $clog2(DWELL)      : 1;
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (DWELL < 1 || CLK_HZ < 2 * BLINK_HZ) begin : g_bad_params
    $error("rtc_settable_clk: illegal CLK_HZ/REFRESH_HZ/BLINK_HZ combination");
  end

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HR  = 2'd1,
    ST_MIN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [4:0]    hr;
  logic [5:0]    mn;
  logic [5:0]    sc;
  logic          set_q;
  logic          inc_q;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_off;

  logic          set_press;
  logic          inc_press;
  logic          tick;
  logic [4:0]    disp_hr;
  logic [15:0]   page;
  logic [3:0]    digit;
  logic          edit_digit;
  logic [3:0]    anode_nxt;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return {4'(t), 4'(v - t * 6'd10)};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Set has priority: an inc edge in the same cycle as a set edge is dropped.
  assign set_press = btn_set & ~set_q;
  assign inc_press = btn_inc & ~inc_q & ~set_press;
  assign tick      = (state == ST_RUN) && (presc == PW'(CLK_HZ - 1));

  assign sec_tick  = tick;
  assign set_state = state;
  assign hr_bcd    = to_bcd(6'(hr));
  assign min_bcd   = to_bcd(mn);
  assign sec_bcd   = to_bcd(sc);
  assign pm        = (hr >= 5'd12);

  // Display page, digit selection and blink masking for the next scan slot.
  always_comb begin
    disp_hr = hr;
    if (fmt12) begin
      if (hr == 5'd0)       disp_hr = 5'd12;
      else if (hr > 5'd12)  disp_hr = hr - 5'd12;
    end
    page  = mode ? {min_bcd, sec_bcd} : {to_bcd(6'(disp_hr)), min_bcd};
    digit = page[4*idx +: 4];
    edit_digit = 1'b0;
    case (state)
      ST_HR:   edit_digit = ~mode & idx[1];
      ST_MIN:  edit_digit = mode ? idx[1] : ~idx[1];
      default: edit_digit = 1'b0;
    endcase
    anode_nxt = ~(4'b0001 << idx);
    if (blink_off && edit_digit) anode_nxt = 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      presc       <= '0;
      hr          <= '0;
      mn          <= '0;
      sc          <= '0;
      set_q       <= 1'b0;
      inc_q       <= 1'b0;
      dwell_cnt   <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      basys_anode <= 4'b1111;
      display_ssd <= 7'b1111111;
    end else begin
      set_q       <= btn_set;
      inc_q       <= btn_inc;
      basys_anode <= anode_nxt;
      display_ssd <= seg7(digit);

      if (dwell_cnt == DW'(DWELL - 1)) begin
        dwell_cnt <= '0;
        idx       <= idx + 2'd1;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end

      // Entering either edit state restarts the blink in its visible phase.
      if (set_press && state != ST_MIN) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end

      case (state)
        ST_RUN: begin
          if (tick) begin
            presc <= '0;
            if (sc == 6'd59) begin
              sc <= '0;
              if (mn == 6'd59) begin
                mn <= '0;
                hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
              end else begin
                mn <= mn + 6'd1;
              end
            end else begin
              sc <= sc + 6'd1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
          if (set_press) state <= ST_HR;
        end
        ST_HR: begin
          if (set_press)      state <= ST_MIN;
          else if (inc_press) hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end
        ST_MIN: begin
          if (set_press) begin
            state <= ST_RUN;
            sc    <= '0;
            presc <= '0;
          end else if (inc_press) begin
            mn <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
